// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized LEGv8 data memory.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    function automatic logic [3:0] size_bytes(mem_size_t sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: extracts/extends load data and merges
// store data into the addressed lanes of one memory word.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    localparam int OFFB  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [OFFB-1:0]   offset,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word
);

    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] shifted;
    logic [OFFB+2:0]   shamt;
    logic              sign_bit;

    // The caller never passes SZ_D on a 32-bit build, so default is full width.
    always_comb begin
        shamt   = {offset, 3'b000};
        shifted = word >> shamt;
        case (mem_size_t'(size))
            SZ_B: begin
                lane_mask = DATA_W'(8'hFF);
                sign_bit  = shifted[7];
            end
            SZ_H: begin
                lane_mask = DATA_W'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            SZ_W: begin
                lane_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                lane_mask = '1;
                sign_bit  = shifted[DATA_W-1];
            end
        endcase
        load_val = shifted & lane_mask;
        if (sign_ext && sign_bit) begin
            load_val = load_val | ~lane_mask;
        end
        store_word = (word & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
    end

endmodule

// File: rtl/data_memory_sized.sv
// Sized data memory with valid/ready handshake and configurable latency.
// Optional macro DMEM_ALIGN_CHECK_EN adds a fault output for misaligned requests.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              mem_clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] read_data
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic              fault
`endif
);

    localparam int OFFB = $clog2(DATA_W / 8);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    dmem_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              write_q, write_d;
    mem_size_t         size_q, size_d;
    logic              signed_q, signed_d;
    logic [OFFB-1:0]   off_q, off_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [3:0]        nbytes_m1;
    logic [OFFB-1:0]   low_mask;
    logic [OFFB-1:0]   aligned_off;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;
    logic              access;
    logic              access_ok;

    // Sub-size offset bits are dropped, so misaligned accesses align down.
    assign nbytes_m1   = size_bytes(size_q) - 4'd1;
    assign low_mask    = nbytes_m1[OFFB-1:0];
    assign aligned_off = off_q & ~low_mask;
    assign access      = (state_q == WAIT) && (cnt_q == '0);

`ifdef DMEM_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misaligned;
    assign misaligned = (off_q & low_mask) != '0;
    assign access_ok  = !misaligned;
    assign fault      = fault_q;
`else
    assign access_ok  = 1'b1;
`endif

    dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
        .word       (mem[idx_q]),
        .offset     (aligned_off),
        .size       (size_q),
        .sign_ext   (signed_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge mem_clk) begin
        if (access && write_q && access_ok) begin
            mem[idx_q] <= store_word;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        ready_d  = ready_q;
        resp_d   = 1'b0;
        rdata_d  = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        fault_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = (DATA_W == 32 && req_size == 2'd3) ? SZ_W : mem_size_t'(req_size);
                    signed_d = req_signed;
                    off_d    = addr[OFFB-1:0];
                    idx_d    = addr[OFFB+IDXW-1:OFFB];
                    wdata_d  = write_data;
                    cnt_d    = CW'(LATENCY - 1);
                    ready_d  = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    resp_d  = 1'b1;
                    rdata_d = (write_q || !access_ok) ? '0 : load_val;
`ifdef DMEM_ALIGN_CHECK_EN
                    fault_d = misaligned;
`endif
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= SZ_B;
            signed_q <= 1'b0;
            off_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_q;
    assign read_data  = rdata_q;

endmodule
